// File: rtl/alu_operand_stage.sv
// Operand staging in front of a combinational ALU: holds A/B/op/carry stable for a
// programmable settle time, then captures the ALU result and (optionally) its flags.
package alu_operand_stage_pkg;
    typedef enum logic [5:0] {
        ALU_ADD  = 6'd0,
        ALU_SUB  = 6'd1,
        ALU_AND  = 6'd2,
        ALU_OR   = 6'd3,
        ALU_XOR  = 6'd4,
        ALU_NOT  = 6'd5,
        ALU_PASS = 6'd6
    } alu_op_e;
endpackage

module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [3:0]  FLAG_INIT     = 4'h0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [15:0]   i_bus,
    input  logic          i_load_a,
    input  logic          i_load_b,
    input  logic          i_flag_load,
    input  alu_op_e       i_op,
    input  logic          i_use_carry,
    input  logic          i_flag_we,
    input  logic          i_start,
    output logic          o_ready,
    output alu_op_e       o_alu_ctrl,
    output logic [15:0]   o_alu_a,
    output logic [15:0]   o_alu_b,
    output logic          o_alu_carry,
    input  logic [15:0]   i_alu_data,
    input  logic [3:0]    i_alu_flag,
    output logic [15:0]   o_result,
    output logic [3:0]    o_flag,
    output logic          o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 32'd1);

    state_e      state_r;
    state_e      state_next_s;
    logic [3:0]  cnt_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [15:0] result_r;
    logic [3:0]  flag_r;
    alu_op_e     op_r;
    logic        carry_r;
    logic        flag_we_r;
    logic        ready_r;
    logic        done_r;
    logic        idle_s;
    logic        start_s;
    logic        capture_s;

    // Decode the current state into the enables used by the datapath registers
    always_comb begin
        idle_s    = (state_r == ST_IDLE);
        start_s   = idle_s & i_start;
        capture_s = (state_r == ST_EXEC) && (cnt_r == 4'd0);
    end

    // Next-state logic for the IDLE -> EXEC -> DONE sequence
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered status outputs; done tracks the single DONE cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_next_s == ST_IDLE);
            done_r  <= capture_s;
        end
    end

    // Operand registers, writable only while idle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_r <= 16'h0000;
            b_r <= 16'h0000;
        end else if (idle_s) begin
            if (i_load_a) begin
                a_r <= i_bus;
            end
            if (i_load_b) begin
                b_r <= i_bus;
            end
        end
    end

    // Issue registers and settle counter; carry samples the flag value before any same-cycle load
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_r      <= ALU_ADD;
            flag_we_r <= 1'b0;
            carry_r   <= 1'b0;
            cnt_r     <= 4'd0;
        end else if (start_s) begin
            op_r      <= i_op;
            flag_we_r <= i_flag_we;
            carry_r   <= i_use_carry & flag_r[3];
            cnt_r     <= CNT_LOAD;
        end else if ((state_r == ST_EXEC) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Result and flag capture; flags are stored exactly as the ALU or bus supplies them
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            result_r <= 16'h0000;
            flag_r   <= FLAG_INIT;
        end else if (capture_s) begin
            result_r <= i_alu_data;
            if (flag_we_r) begin
                flag_r <= i_alu_flag;
            end
        end else if (idle_s && i_flag_load) begin
            flag_r <= i_bus[3:0];
        end
    end

    assign o_ready     = ready_r;
    assign o_done      = done_r;
    assign o_alu_ctrl  = op_r;
    assign o_alu_a     = a_r;
    assign o_alu_b     = b_r;
    assign o_alu_carry = carry_r;
    assign o_result    = result_r;
    assign o_flag      = flag_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: two instances (settle 1 and settle 4), each
// with a behavioural ALU attached whose S and Z flags are active-low.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus;
    logic        load_a;
    logic        load_b;
    logic        flag_load;
    logic        use_carry;
    logic        flag_we;
    alu_op_e     op;
    logic [1:0]  start;

    logic        ready     [2];
    alu_op_e     alu_ctrl  [2];
    logic [15:0] alu_a     [2];
    logic [15:0] alu_b     [2];
    logic        alu_carry [2];
    logic [15:0] alu_data  [2];
    logic [3:0]  alu_flag  [2];
    logic [15:0] result    [2];
    logic [3:0]  flag      [2];
    logic        done      [2];

    logic [15:0] exp_a     [2];
    logic [15:0] exp_b     [2];
    logic [3:0]  exp_flag  [2];
    int          settle_of [2] = '{1, 4};
    logic [3:0]  finit_of  [2] = '{4'h0, 4'hA};
    int          done_seen [2] = '{0, 0};
    logic [20:0] sb_q [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [19:0] alu_model(alu_op_e o, logic [15:0] a, logic [15:0] b, logic c);
        logic [16:0] s;
        logic [15:0] r;
        logic        co;
        logic        v;
        s  = 17'd0;
        r  = 16'h0000;
        co = 1'b0;
        v  = 1'b0;
        case (o)
            ALU_ADD: begin
                s  = {1'b0, a} + {1'b0, b} + {16'd0, c};
                r  = s[15:0];
                co = s[16];
                v  = (a[15] == b[15]) && (r[15] != a[15]);
            end
            ALU_SUB: begin
                s  = {1'b0, a} - {1'b0, b} - {16'd0, c};
                r  = s[15:0];
                co = s[16];
                v  = (a[15] != b[15]) && (r[15] != a[15]);
            end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOT:  r = ~a;
            ALU_PASS: r = b;
            default:  r = 16'h0000;
        endcase
        return {co, ~r[15], v, ~(r == 16'h0000), r};
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        alu_operand_stage #(
            .SETTLE_CYCLES(k == 0 ? 1 : 4),
            .FLAG_INIT    (k == 0 ? 4'h0 : 4'hA)
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_bus       (bus),
            .i_load_a    (load_a),
            .i_load_b    (load_b),
            .i_flag_load (flag_load),
            .i_op        (op),
            .i_use_carry (use_carry),
            .i_flag_we   (flag_we),
            .i_start     (start[k]),
            .o_ready     (ready[k]),
            .o_alu_ctrl  (alu_ctrl[k]),
            .o_alu_a     (alu_a[k]),
            .o_alu_b     (alu_b[k]),
            .o_alu_carry (alu_carry[k]),
            .i_alu_data  (alu_data[k]),
            .i_alu_flag  (alu_flag[k]),
            .o_result    (result[k]),
            .o_flag      (flag[k]),
            .o_done      (done[k])
        );
        assign {alu_flag[k], alu_data[k]} = alu_model(alu_ctrl[k], alu_a[k], alu_b[k], alu_carry[k]);
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop one expected result per done pulse and compare against the captured registers
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (done[k] === 1'b1) begin
                logic [20:0] e;
                done_seen[k]++;
                check("sb_pending", 32'(sb_q.size()), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("sb_id", 32'(e[20]), 32'(k));
                    check("sb_result", 32'(result[k]), 32'(e[15:0]));
                    check("sb_flag", 32'(flag[k]), 32'(e[19:16]));
                end
            end
        end
    end

    task automatic load_ops(logic la, logic lb, logic [15:0] v);
        bus    = v;
        load_a = la;
        load_b = lb;
        tick();
        load_a = 1'b0;
        load_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (la) exp_a[k] = v;
            if (lb) exp_b[k] = v;
        end
    endtask

    task automatic load_flag(logic [15:0] v);
        bus       = v;
        flag_load = 1'b1;
        tick();
        flag_load = 1'b0;
        for (int k = 0; k < 2; k++) exp_flag[k] = v[3:0];
    endtask

    task automatic run_op(int d, alu_op_e o, logic we, logic uc, logic la, logic fl,
                          logic [15:0] v, logic disturb);
        logic        c;
        logic [19:0] r;
        int          cnt;
        bus       = v;
        load_a    = la;
        flag_load = fl;
        op        = o;
        flag_we   = we;
        use_carry = uc;
        start[d]  = 1'b1;
        c = uc ? exp_flag[d][3] : 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (la) exp_a[k] = v;
            if (fl) exp_flag[k] = v[3:0];
        end
        r = alu_model(o, exp_a[d], exp_b[d], c);
        if (we) exp_flag[d] = r[19:16];
        sb_q.push_back({d[0], exp_flag[d], r[15:0]});
        tick();
        start     = 2'b00;
        load_a    = 1'b0;
        flag_load = 1'b0;
        cnt       = 0;
        while (!done[d] && cnt < 20) begin
            check("exec_ready", 32'(ready[d]), 32'd0);
            check("exec_alu_a", 32'(alu_a[d]), 32'(exp_a[d]));
            check("exec_alu_b", 32'(alu_b[d]), 32'(exp_b[d]));
            check("exec_carry", 32'(alu_carry[d]), 32'(c));
            check("exec_ctrl", 32'(alu_ctrl[d]), 32'(o));
            if (disturb && cnt == 1) begin
                bus      = 16'h5555;
                load_a   = 1'b1;
                start[d] = 1'b1;
                exp_a[1 - d] = 16'h5555;
            end else begin
                load_a   = 1'b0;
                start[d] = 1'b0;
            end
            tick();
            cnt++;
        end
        load_a = 1'b0;
        start  = 2'b00;
        check("latency", 32'(cnt), 32'(settle_of[d]));
        check("done_ready", 32'(ready[d]), 32'd0);
        tick();
        check("done_len", 32'(done[d]), 32'd0);
        check("ready_back", 32'(ready[d]), 32'd1);
        check("hold_result", 32'(result[d]), 32'(r[15:0]));
        check("hold_flag", 32'(flag[d]), 32'(exp_flag[d]));
        check("hold_ctrl", 32'(alu_ctrl[d]), 32'(o));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        rst       = 1'b1;
        bus       = 16'h0000;
        load_a    = 1'b0;
        load_b    = 1'b0;
        flag_load = 1'b0;
        use_carry = 1'b0;
        flag_we   = 1'b0;
        op        = ALU_ADD;
        start     = 2'b00;
        for (int k = 0; k < 2; k++) begin
            exp_a[k]    = 16'h0000;
            exp_b[k]    = 16'h0000;
            exp_flag[k] = finit_of[k];
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            check("rst_ready", 32'(ready[k]), 32'd1);
            check("rst_done", 32'(done[k]), 32'd0);
            check("rst_result", 32'(result[k]), 32'd0);
            check("rst_flag", 32'(flag[k]), 32'(finit_of[k]));
            check("rst_alu_a", 32'(alu_a[k]), 32'd0);
            check("rst_carry", 32'(alu_carry[k]), 32'd0);
        end
        rst = 1'b0;
        tick();

        // 3 + 4 with flags
        load_ops(1'b1, 1'b0, 16'h0003);
        load_ops(1'b0, 1'b1, 16'h0004);
        run_op(0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("add_result", 32'(result[0]), 32'h0007);
        check("add_flag", 32'(flag[0]), 32'h5);

        // carry-out wraps to zero, then XOR leaves flags alone
        load_ops(1'b1, 1'b0, 16'hFFFF);
        load_ops(1'b0, 1'b1, 16'h0001);
        run_op(0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("wrap_result", 32'(result[0]), 32'h0000);
        check("wrap_flag", 32'(flag[0]), 32'hC);
        load_ops(1'b1, 1'b0, 16'h1234);
        run_op(0, ALU_XOR, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("xor_result", 32'(result[0]), 32'h1235);
        check("xor_flag", 32'(flag[0]), 32'hC);

        // carry-in from a bus-loaded flag register, on both settle times
        load_flag(16'h0008);
        run_op(0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("cin_result", 32'(result[0]), 32'h1236);
        run_op(1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        run_op(1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("nocin_result", 32'(result[1]), 32'h1235);

        // loads and start during a long EXEC are ignored
        run_op(1, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        check("sub_result", 32'(result[1]), 32'h1233);

        // flag load with start: carry uses the old C, flag register takes the bus value
        load_flag(16'h0008);
        run_op(0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
        check("fl_start_flag", 32'(flag[0]), 32'h0);

        // operand load with start feeds the same operation
        run_op(0, ALU_NOT, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00AA, 1'b0);
        check("not_result", 32'(result[0]), 32'hFF55);
        run_op(1, ALU_OR, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b0);

        // reset in the second EXEC cycle aborts the operation
        load_flag(16'h0008);
        op        = ALU_XOR;
        use_carry = 1'b1;
        flag_we   = 1'b1;
        start[1]  = 1'b1;
        tick();
        start = 2'b00;
        tick();
        seen = done_seen[1];
        rst  = 1'b1;
        #1;
        check("abort_ready", 32'(ready[1]), 32'd1);
        check("abort_done", 32'(done[1]), 32'd0);
        check("abort_result", 32'(result[1]), 32'd0);
        check("abort_flag", 32'(flag[1]), 32'hA);
        check("abort_alu_a", 32'(alu_a[1]), 32'd0);
        check("abort_carry", 32'(alu_carry[1]), 32'd0);
        check("abort_ctrl", 32'(alu_ctrl[1]), 32'(ALU_ADD));
        for (int k = 0; k < 2; k++) begin
            exp_a[k]    = 16'h0000;
            exp_b[k]    = 16'h0000;
            exp_flag[k] = finit_of[k];
        end
        tick();
        rst = 1'b0;
        repeat (8) tick();
        check("abort_no_done", 32'(done_seen[1]), 32'(seen));
        check("abort_hold_result", 32'(result[1]), 32'd0);

        // first start after reset behaves normally
        load_ops(1'b1, 1'b0, 16'h0005);
        load_ops(1'b0, 1'b1, 16'h0006);
        run_op(1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("post_rst_result", 32'(result[1]), 32'h000B);
        check("post_rst_flag", 32'(flag[1]), 32'h5);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
